// File: rtl/axi_read_master.sv
// Single-outstanding AXI read master: one core request becomes one INCR AR burst,
// and the R beats are passed straight through to the core with last/error tagging.
module axi_read_master #(
    parameter int          ID_W      = 4,
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int          LEN_W     = 4,
    parameter int unsigned MASTER_ID = 0
) (
    input  logic              clk,
    input  logic              ARSTN,
    // core request side
    input  logic              rq_valid,
    output logic              rq_ready,
    input  logic [ADDR_W-1:0] rq_addr,
    input  logic [LEN_W-1:0]  rq_len,
    // core read data side
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              rd_err,
    // AXI AR channel
    output logic [ID_W-1:0]   M_ARID,
    output logic [ADDR_W-1:0] M_ARAddr,
    output logic [LEN_W-1:0]  M_ARLen,
    output logic [2:0]        M_ARSize,
    output logic [1:0]        M_ARBurst,
    output logic              M_ARValid,
    input  logic              M_ARReady,
    // AXI R channel
    input  logic [ID_W-1:0]   M_RID,
    input  logic [DATA_W-1:0] M_RData,
    input  logic [1:0]        M_RResp,
    input  logic              M_RLast,
    input  logic              M_RValid,
    output logic              M_RReady
);

    localparam logic [ID_W-1:0] MID = ID_W'(MASTER_ID);

    typedef enum logic [1:0] {IDLE, RADDR, RDATA} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [LEN_W-1:0]  arlen_q;
    logic [LEN_W-1:0]  cnt_q;

    logic in_data;
    logic cnt_hit;
    logic beat_acc;
    logic beat_final;
    logic unused_addr_lsbs;

    // Addresses are word aligned, so the byte offset bits are dropped.
    assign unused_addr_lsbs = ^rq_addr[1:0];

    assign rq_ready  = (state_q == IDLE);
    assign M_ARValid = (state_q == RADDR);
    assign M_ARAddr  = araddr_q;
    assign M_ARLen   = arlen_q;
    assign M_ARID    = MID;
    assign M_ARSize  = 3'b010;
    assign M_ARBurst = 2'b01;

    assign in_data    = (state_q == RDATA);
    assign M_RReady   = in_data & rd_ready;
    assign rd_valid   = in_data & M_RValid;
    assign rd_data    = in_data ? M_RData : '0;
    assign cnt_hit    = (cnt_q == arlen_q);
    assign beat_acc   = rd_valid & rd_ready;
    assign beat_final = cnt_hit | M_RLast;

    // Tags are shown with the presented beat so the core sees them at its handshake.
    assign rd_last = rd_valid & beat_final;
    assign rd_err  = rd_valid & ((M_RResp != 2'b00) | (M_RID != MID) | (M_RLast != cnt_hit));

    always_ff @(posedge clk or negedge ARSTN) begin
        if (!ARSTN) begin
            state_q  <= IDLE;
            araddr_q <= '0;
            arlen_q  <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rq_valid) begin
                        araddr_q <= {rq_addr[ADDR_W-1:2], 2'b00};
                        arlen_q  <= rq_len;
                        cnt_q    <= '0;
                        state_q  <= RADDR;
                    end
                end
                RADDR: begin
                    if (M_ARReady) state_q <= RDATA;
                end
                RDATA: begin
                    // Either an early RLast or the expected count closes the burst,
                    // so the counter stops at ARLen and never wraps.
                    if (beat_acc) begin
                        if (beat_final) state_q <= IDLE;
                        else            cnt_q   <= cnt_q + LEN_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_master.sv
// Bench for axi_read_master: a table of bursts driven through a small slave model,
// with expected beats queued on presentation and checked at the core handshake.
module tb_axi_read_master;

    logic        clk;
    logic        ARSTN;
    logic        rq_valid;
    logic        rq_ready;
    logic [31:0] rq_addr;
    logic [3:0]  rq_len;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        rd_err;
    logic [3:0]  M_ARID;
    logic [31:0] M_ARAddr;
    logic [3:0]  M_ARLen;
    logic [2:0]  M_ARSize;
    logic [1:0]  M_ARBurst;
    logic        M_ARValid;
    logic        M_ARReady;
    logic [3:0]  M_RID;
    logic [31:0] M_RData;
    logic [1:0]  M_RResp;
    logic        M_RLast;
    logic        M_RValid;
    logic        M_RReady;

    axi_read_master #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .LEN_W(4), .MASTER_ID(0)) dut (
        .clk(clk), .ARSTN(ARSTN),
        .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_addr(rq_addr), .rq_len(rq_len),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .rd_err(rd_err),
        .M_ARID(M_ARID), .M_ARAddr(M_ARAddr), .M_ARLen(M_ARLen), .M_ARSize(M_ARSize),
        .M_ARBurst(M_ARBurst), .M_ARValid(M_ARValid), .M_ARReady(M_ARReady),
        .M_RID(M_RID), .M_RData(M_RData), .M_RResp(M_RResp), .M_RLast(M_RLast),
        .M_RValid(M_RValid), .M_RReady(M_RReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        e;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
        int          delay;
        int          err_beat;
        int          early;
        bit          drop;
        int          badid;
        bit          tog;
        logic [31:0] data0;
        logic [31:0] exp_addr;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got no handshake expected one within bound", name);
    endtask

    // Scoreboard: every accepted core beat must match the oldest presented beat.
    always @(negedge clk) begin
        if (ARSTN && rd_valid && rd_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", {31'd0, rd_last, rd_err, rd_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("beat", {30'd0, rd_last, rd_err, rd_data}, {30'd0, e.l, e.e, e.d});
            end
        end
    end

    task automatic req(input logic [31:0] a, input logic [3:0] l);
        @(posedge clk); #1;
        rq_valid = 1'b1;
        rq_addr  = a;
        rq_len   = l;
        @(negedge clk);
        chk("rq_ready", {63'd0, rq_ready}, 64'd1);
    endtask

    task automatic ar_phase(input int delay, input logic [31:0] ea, input logic [3:0] el,
                            input bit hold, input int exp_first);
        int k;
        int first;
        int it;
        k = 0; first = -1; it = 0;
        forever begin
            @(posedge clk); #1;
            M_RValid = 1'b0;
            if (!hold && M_ARValid) rq_valid = 1'b0;
            M_ARReady = M_ARValid && (k >= delay);
            @(negedge clk);
            if (M_ARValid) begin
                if (first < 0) begin
                    first = it;
                    chk("ar_const", {55'd0, M_ARID, M_ARSize, M_ARBurst}, {55'd0, 4'h0, 3'b010, 2'b01});
                end
                chk("ar_addr", {32'd0, M_ARAddr}, {32'd0, ea});
                chk("ar_len", {60'd0, M_ARLen}, {60'd0, el});
                k++;
                if (M_ARReady) break;
            end
            it++;
            if (it > 40) begin
                fail_now("ar_timeout");
                break;
            end
        end
        chk("ar_first", 64'(first), 64'(exp_first));
        chk("ar_cycles", 64'(k), 64'(delay + 1));
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic [3:0] id,
                        input logic last, input bit tog, input logic el, input logic ee);
        exp_t e;
        @(posedge clk); #1;
        M_ARReady = 1'b0;
        M_RValid  = 1'b1;
        M_RData   = d;
        M_RResp   = resp;
        M_RID     = id;
        M_RLast   = last;
        rd_ready  = tog ? ~rd_ready : 1'b1;
        e.d = d; e.l = el; e.e = ee;
        sb.push_back(e);
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (M_RValid && M_RReady) break;
            if (n > 20) begin
                fail_now("beat_timeout");
                break;
            end
            @(posedge clk); #1;
            rd_ready = tog ? ~rd_ready : 1'b1;
        end
    endtask

    // Cycle after a final beat: master must be idle and must not absorb a stray beat.
    task automatic stray();
        @(posedge clk); #1;
        M_ARReady = 1'b0;
        M_RValid  = 1'b1;
        M_RLast   = 1'b1;
        rd_ready  = 1'b1;
        @(negedge clk);
        chk("idle_rq_ready", {63'd0, rq_ready}, 64'd1);
        chk("stray_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("stray_rready", {63'd0, M_RReady}, 64'd0);
        @(posedge clk); #1;
        M_RValid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int   nb;
        logic rl;
        logic fin;
        logic er;
        nb = (v.early >= 0) ? v.early + 1 : int'(v.len) + 1;
        rd_ready = 1'b0;
        req(v.addr, v.len);
        ar_phase(v.delay, v.exp_addr, v.len, 1'b0, 0);
        for (int i = 0; i < nb; i++) begin
            rl  = (i == v.early) || (i == int'(v.len) && !v.drop);
            fin = rl || (i == int'(v.len));
            er  = (i == v.err_beat) || (i == v.badid) || (rl != (i == int'(v.len)));
            beat(v.data0 + 32'(i), (i == v.err_beat) ? 2'b10 : 2'b00,
                 (i == v.badid) ? 4'h5 : 4'h0, rl, v.tog, fin, er);
        end
        stray();
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h0000_1006, 4'd0,  0, -1, -1, 1'b0, -1, 1'b0, 32'hDEAD_BEEF, 32'h0000_1004};
        vecs[1] = '{32'h0000_2000, 4'd3,  3, -1, -1, 1'b0, -1, 1'b1, 32'h1111_0000, 32'h0000_2000};
        vecs[2] = '{32'h0000_3008, 4'd3,  1,  2, -1, 1'b0, -1, 1'b0, 32'h2222_0000, 32'h0000_3008};
        vecs[3] = '{32'h0000_4000, 4'd3,  0, -1,  1, 1'b0, -1, 1'b0, 32'h3333_0000, 32'h0000_4000};
        vecs[4] = '{32'h0000_5003, 4'd15, 0, -1, -1, 1'b0, -1, 1'b0, 32'h4444_0000, 32'h0000_5000};
        vecs[5] = '{32'h0000_6000, 4'd2,  0, -1, -1, 1'b1, -1, 1'b0, 32'h5555_0000, 32'h0000_6000};
        vecs[6] = '{32'h0000_7001, 4'd1,  0, -1, -1, 1'b0,  0, 1'b1, 32'h6666_0000, 32'h0000_7000};
        vecs[7] = '{32'h0000_8FFC, 4'd0,  2, -1, -1, 1'b0, -1, 1'b0, 32'h7777_0000, 32'h0000_8FFC};

        ARSTN = 1'b0; rq_valid = 1'b0; rq_addr = '0; rq_len = '0; rd_ready = 1'b0;
        M_ARReady = 1'b0; M_RID = '0; M_RData = '0; M_RResp = '0; M_RLast = 1'b0;
        M_RValid = 1'b1;
        #3;
        chk("rst_rq_ready", {63'd0, rq_ready}, 64'd1);
        chk("rst_ar", {31'd0, M_ARValid, M_ARAddr}, 64'd0);
        chk("rst_arlen", {60'd0, M_ARLen}, 64'd0);
        chk("rst_rd", {60'd0, M_RReady, rd_valid, rd_last, rd_err}, 64'd0);
        @(posedge clk); @(posedge clk); #3;
        M_RValid = 1'b0;
        ARSTN = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of a burst, two beats in.
        rd_ready = 1'b0;
        req(32'h0000_9000, 4'd3);
        ar_phase(0, 32'h0000_9000, 4'd3, 1'b0, 0);
        beat(32'hA000_0000, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(32'hA000_0001, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        M_RValid = 1'b1; M_RData = 32'hA000_0002; rd_ready = 1'b1;
        #1 ARSTN = 1'b0;
        #1;
        chk("mid_rst_rq_ready", {63'd0, rq_ready}, 64'd1);
        chk("mid_rst_ar", {31'd0, M_ARValid, M_ARAddr}, 64'd0);
        chk("mid_rst_arlen", {60'd0, M_ARLen}, 64'd0);
        chk("mid_rst_rd", {60'd0, M_RReady, rd_valid, rd_last, rd_err}, 64'd0);
        @(posedge clk); #2;
        ARSTN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_rd_valid", {62'd0, rd_valid, M_RReady}, 64'd0);
        end
        @(posedge clk); #1;
        M_RValid = 1'b0;

        // Back-to-back requests with rq_valid held high.
        rd_ready = 1'b0;
        req(32'h0000_A000, 4'd0);
        ar_phase(0, 32'h0000_A000, 4'd0, 1'b1, 0);
        beat(32'hB000_0000, 2'b00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        rq_addr = 32'h0000_B010;
        rq_len  = 4'd1;
        ar_phase(0, 32'h0000_B010, 4'd1, 1'b0, 1);
        beat(32'hC000_0000, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat(32'hC000_0001, 2'b00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        stray();

        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_read_master.md
AXI_READ_MASTER -- requirements
Module: axi_read_master

Interface
REQ-001 Parameters SHALL be: ID_W 4 AXI ID width; ADDR_W 32 address width; DATA_W 32 data width; LEN_W 4 burst length width; MASTER_ID 0 ARID value driven.
REQ-002 clk  input  1  single clock, all flops rising-edge.
REQ-003 ARSTN  input  1  reset, asynchronous assert, active-low.
REQ-004 rq_valid  input  1  core read request.
REQ-005 rq_ready  output  1  request accepted when rq_valid & rq_ready.
REQ-006 rq_addr  input  ADDR_W  burst start byte address.
REQ-007 rq_len  input  LEN_W  beats minus one.
REQ-008 rd_valid  output  1  read beat available to core.
REQ-009 rd_ready  input  1  core accepts beat.
REQ-010 rd_data  output  DATA_W  beat data.
REQ-011 rd_last  output  1  final beat of burst.
REQ-012 rd_err  output  1  beat carries protocol/response error.
REQ-013 M_ARID  output  ID_W  read address ID.
REQ-014 M_ARAddr  output  ADDR_W  read address.
REQ-015 M_ARLen  output  LEN_W  burst length.
REQ-016 M_ARSize  output  3  beat size.
REQ-017 M_ARBurst  output  2  burst type.
REQ-018 M_ARValid  output  1  AR valid.
REQ-019 M_ARReady  input  1  AR ready from slave.
REQ-020 M_RID  input  ID_W  R ID.
REQ-021 M_RData  input  DATA_W  R data.
REQ-022 M_RResp  input  2  R response.
REQ-023 M_RLast  input  1  R last.
REQ-024 M_RValid  input  1  R valid.
REQ-025 M_RReady  output  1  R ready.

Function
REQ-026 FSM SHALL have states IDLE, RADDR, RDATA; IDLE->RADDR on rq_valid; RADDR->RDATA on M_ARValid & M_ARReady; RDATA->IDLE on final accepted beat (REQ-032); all else hold.
REQ-027 rq_ready SHALL be 1 exactly in IDLE (combinational from state).
REQ-028 On request acceptance: register {rq_addr[ADDR_W-1:2], 2'b00} to M_ARAddr, rq_len to M_ARLen, clear beat counter; M_ARValid=1 from the next cycle, i.e. 1-cycle request-to-AR latency.
REQ-029 M_ARValid SHALL be 1 exactly in RADDR; M_ARAddr/M_ARLen stable while M_ARValid=1 and not M_ARReady; M_ARID=MASTER_ID, M_ARSize=3'b010, M_ARBurst=2'b01 (INCR) constant.
REQ-030 In RDATA: M_RReady=rd_ready, rd_valid=M_RValid, rd_data=M_RData; beat accepted on M_RValid & M_RReady; 0 elsewhere.
REQ-031 Beat counter (LEN_W bits) SHALL increment per accepted beat; max 16 beats, counter never wraps within a burst.
REQ-032 Final beat = accepted beat with counter==M_ARLen OR M_RLast=1; rd_last=1 on it.
REQ-033 rd_err=1 on an accepted beat when M_RResp!=2'b00, M_RID!=MASTER_ID, or M_RLast != (counter==M_ARLen).
REQ-034 Early M_RLast SHALL end the burst (IDLE) with rd_err=1; missing M_RLast at counter==M_ARLen SHALL end the burst with rd_err=1; no further beats absorbed.
REQ-035 Return to IDLE SHALL cost one cycle; next AR no earlier than 2 cycles after final beat.
REQ-036 No 4KB-boundary check; caller guarantees bursts do not cross 4KB.
REQ-037 M_RValid while in IDLE/RADDR SHALL be ignored (M_RReady=0).

Reset
REQ-038 ARSTN=0 SHALL force IDLE, M_ARValid=0, M_ARAddr=0, M_ARLen=0, counter=0, M_RReady=0, rd_valid=0, rd_last=0, rd_err=0, rq_ready=1, immediately and asynchronously.
REQ-039 Reset mid-burst SHALL abandon the transaction; no beat delivered after deassertion until a new request.

Verification
REQ-040 Single beat: rq_addr=0x0000_1006, rq_len=0; slave ARReady same cycle, one R beat 0xDEADBEEF RLast=1 -> M_ARAddr=0x0000_1004, ARLen=0, rd_data=0xDEADBEEF, rd_last=1, rd_err=0, IDLE next cycle.
REQ-041 Burst len=3, ARReady delayed 3 cycles, rd_ready toggling -> ARValid held 4 cycles with stable address, exactly 4 beats delivered in order, rd_last only on 4th.
REQ-042 Error response: beat 2 of len=3 with RResp=2'b10 -> rd_err=1 on that beat only, burst completes normally.
REQ-043 Early RLast on beat 1 of len=3 -> rd_last=1, rd_err=1, IDLE, rq_ready=1 next cycle.
REQ-044 ARSTN low during RDATA after 2 beats -> outputs at reset values immediately; stray RValid after release produces no rd_valid.
REQ-045 Back-to-back requests with rq_valid held high -> second AR issued 2 cycles after first burst's final beat.
